// File: rtl/seq_detect_param.sv
// Serial pattern detector with KMP fallback: Z is combinational, Y/X/COUNT/STATE update one edge after the bit.
// No backpressure: a bit on A is consumed on every CLK edge where B is high.
module seq_detect_param #(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
    parameter bit                   OVERLAP   = 1'b1,
    parameter int                   CNT_W     = 8,
    localparam int                  ST_W      = $clog2(PATTERN_W)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             A,
    input  logic             B,
    input  logic             CLR,
    output logic             Y,
    output logic             Z,
    output logic             X,
    output logic [CNT_W-1:0] COUNT,
    output logic [ST_W-1:0]  STATE
);

    localparam logic [ST_W-1:0]  LAST_ST  = ST_W'(PATTERN_W - 1);
    localparam logic             LAST_BIT = PATTERN[0];
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // Bit i of the pattern in arrival order (i = 0 is received first).
    function automatic logic pat_bit(input int i);
        logic [PATTERN_W-1:0] sh;
        sh = PATTERN >> (PATTERN_W - 1 - i);
        return sh[0];
    endfunction

    // Prefix length reached after seeing bit a in state k: the longest border
    // of (pattern prefix of length k, a) that is also a proper pattern prefix.
    function automatic int next_len(input int k, input logic a);
        int   len;
        int   res;
        logic ok;
        logic sb;
        len = k + 1;
        res = 0;
        for (int j = PATTERN_W - 1; j >= 1; j--) begin
            if (res == 0 && j <= len) begin
                ok = 1'b1;
                for (int i = 0; i < j; i++) begin
                    sb = (len - j + i < k) ? pat_bit(len - j + i) : a;
                    if (sb != pat_bit(i)) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    res = j;
                end
            end
        end
        if (!OVERLAP && k == PATTERN_W - 1 && a == pat_bit(k)) begin
            res = 0;
        end
        return res;
    endfunction

    logic [ST_W-1:0] nxt0_tbl [2**ST_W];
    logic [ST_W-1:0] nxt1_tbl [2**ST_W];

    for (genvar g = 0; g < 2**ST_W; g++) begin : g_tbl
        if (g < PATTERN_W) begin : g_live
            localparam int N0 = next_len(g, 1'b0);
            localparam int N1 = next_len(g, 1'b1);
            assign nxt0_tbl[g] = ST_W'(N0);
            assign nxt1_tbl[g] = ST_W'(N1);
        end else begin : g_pad
            assign nxt0_tbl[g] = '0;
            assign nxt1_tbl[g] = '0;
        end
    end

    logic [ST_W-1:0]  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             y_q, y_d;
    logic             x_q, x_d;
    logic             complete;

    always_comb begin
        complete = B && (state_q == LAST_ST) && (A == LAST_BIT);
        state_d  = state_q;
        if (B) begin
            state_d = A ? nxt1_tbl[state_q] : nxt0_tbl[state_q];
        end
        y_d   = complete;
        x_d   = (state_d != '0);
        cnt_d = cnt_q;
        // Clear takes priority over a match landing on the same edge.
        if (CLR) begin
            cnt_d = '0;
        end else if (complete && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= '0;
            cnt_q   <= '0;
            y_q     <= 1'b0;
            x_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            x_q     <= x_d;
        end
    end

    assign Z     = RST && complete;
    assign Y     = y_q;
    assign X     = x_q;
    assign COUNT = cnt_q;
    assign STATE = state_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: overlapping, non-overlapping and 2-bit-counter instances share stimulus.
module tb_seq_detect_param;

    logic CLK, RST, A, B, CLR;

    logic       y_ov,  z_ov,  x_ov;
    logic [7:0] cnt_ov;
    logic [1:0] st_ov;
    logic       y_nov, z_nov, x_nov;
    logic [7:0] cnt_nov;
    logic [1:0] st_nov;
    logic       y_c2,  z_c2,  x_c2;
    logic [1:0] cnt_c2;
    logic [1:0] st_c2;

    seq_detect_param #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .CLR(CLR),
        .Y(y_ov), .Z(z_ov), .X(x_ov), .COUNT(cnt_ov), .STATE(st_ov)
    );

    seq_detect_param #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_nov (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .CLR(CLR),
        .Y(y_nov), .Z(z_nov), .X(x_nov), .COUNT(cnt_nov), .STATE(st_nov)
    );

    seq_detect_param #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_c2 (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .CLR(CLR),
        .Y(y_c2), .Z(z_c2), .X(x_c2), .COUNT(cnt_c2), .STATE(st_c2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int    sel;
        logic  z;
        int    st;
        int    cnt;
        string nm;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int get_z(input int sel);
        case (sel)
            0:       return int'(z_ov);
            1:       return int'(z_nov);
            default: return int'(z_c2);
        endcase
    endfunction

    function automatic int get_y(input int sel);
        case (sel)
            0:       return int'(y_ov);
            1:       return int'(y_nov);
            default: return int'(y_c2);
        endcase
    endfunction

    function automatic int get_x(input int sel);
        case (sel)
            0:       return int'(x_ov);
            1:       return int'(x_nov);
            default: return int'(x_c2);
        endcase
    endfunction

    function automatic int get_st(input int sel);
        case (sel)
            0:       return int'(st_ov);
            1:       return int'(st_nov);
            default: return int'(st_c2);
        endcase
    endfunction

    function automatic int get_cnt(input int sel);
        case (sel)
            0:       return int'(cnt_ov);
            1:       return int'(cnt_nov);
            default: return int'(cnt_c2);
        endcase
    endfunction

    task automatic chk_all_zero(input string nm);
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("%s dut%0d Z", nm, s), get_z(s), 0);
            chk($sformatf("%s dut%0d Y", nm, s), get_y(s), 0);
            chk($sformatf("%s dut%0d X", nm, s), get_x(s), 0);
            chk($sformatf("%s dut%0d STATE", nm, s), get_st(s), 0);
            chk($sformatf("%s dut%0d COUNT", nm, s), get_cnt(s), 0);
        end
    endtask

    // Monitor: Z checked mid-cycle for the presented bit, registered outputs just after the edge.
    initial begin
        exp_t r;
        forever begin
            @(negedge CLK);
            if (q.size() != 0) begin
                r = q.pop_front();
                chk({r.nm, " Z"}, get_z(r.sel), int'(r.z));
                @(posedge CLK);
                #2;
                chk({r.nm, " Y"}, get_y(r.sel), int'(r.z));
                chk({r.nm, " STATE"}, get_st(r.sel), r.st);
                chk({r.nm, " X"}, get_x(r.sel), (r.st != 0) ? 1 : 0);
                chk({r.nm, " COUNT"}, get_cnt(r.sel), r.cnt);
            end
        end
    end

    // Drive one bit, queue what the selected DUT must show, advance one edge.
    task automatic step(input int sel, input string nm, input logic a, input logic b,
                        input logic clr, input logic ez, input int est, input int ecnt);
        exp_t r;
        A   = a;
        B   = b;
        CLR = clr;
        r.sel = sel;
        r.z   = ez;
        r.st  = est;
        r.cnt = ecnt;
        r.nm  = nm;
        q.push_back(r);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        #2;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        A   = 1'b0;
        B   = 1'b0;
        CLR = 1'b0;
        #1;
        RST = 1'b0;
        #1;
        chk_all_zero("initial_reset");
        @(posedge CLK);
        #1;
        RST = 1'b1;

        // T2 overlap: 1,0,1,1,0,1,1 -> matches at bits 4 and 7
        step(0, "T2.1", 1, 1, 0, 0, 1, 0);
        step(0, "T2.2", 0, 1, 0, 0, 2, 0);
        step(0, "T2.3", 1, 1, 0, 0, 3, 0);
        step(0, "T2.4", 1, 1, 0, 1, 1, 1);
        step(0, "T2.5", 0, 1, 0, 0, 2, 1);
        step(0, "T2.6", 1, 1, 0, 0, 3, 1);
        step(0, "T2.7", 1, 1, 0, 1, 1, 2);
        step(0, "T2.8", 0, 0, 0, 0, 1, 2);

        // T3 non-overlap: same stream -> only bit 4 matches
        do_reset();
        step(1, "T3.1", 1, 1, 0, 0, 1, 0);
        step(1, "T3.2", 0, 1, 0, 0, 2, 0);
        step(1, "T3.3", 1, 1, 0, 0, 3, 0);
        step(1, "T3.4", 1, 1, 0, 1, 0, 1);
        step(1, "T3.5", 0, 1, 0, 0, 0, 1);
        step(1, "T3.6", 1, 1, 0, 0, 1, 1);
        step(1, "T3.7", 1, 1, 0, 0, 1, 1);

        // T4 KMP fallback: 1,0,1,0,1,1
        do_reset();
        step(0, "T4.1", 1, 1, 0, 0, 1, 0);
        step(0, "T4.2", 0, 1, 0, 0, 2, 0);
        step(0, "T4.3", 1, 1, 0, 0, 3, 0);
        step(0, "T4.4", 0, 1, 0, 0, 2, 0);
        step(0, "T4.5", 1, 1, 0, 0, 3, 0);
        step(0, "T4.6", 1, 1, 0, 1, 1, 1);

        // T5 gating: B=0 bits are ignored, including a would-be completing A=1
        do_reset();
        step(0, "T5.1", 1, 1, 0, 0, 1, 0);
        step(0, "T5.2", 0, 0, 0, 0, 1, 0);
        step(0, "T5.3", 0, 1, 0, 0, 2, 0);
        step(0, "T5.4", 1, 0, 0, 0, 2, 0);
        step(0, "T5.5", 0, 0, 0, 0, 2, 0);
        step(0, "T5.6", 1, 1, 0, 0, 3, 0);
        step(0, "T5.7", 1, 0, 0, 0, 3, 0);
        step(0, "T5.8", 1, 1, 0, 1, 1, 1);
        step(0, "T5.9", 1, 0, 0, 0, 1, 1);

        // T6 2-bit counter saturation, then CLR racing a match
        do_reset();
        step(2, "T6.1a", 1, 1, 0, 0, 1, 0);
        step(2, "T6.1b", 0, 1, 0, 0, 2, 0);
        step(2, "T6.1c", 1, 1, 0, 0, 3, 0);
        step(2, "T6.1d", 1, 1, 0, 1, 1, 1);
        step(2, "T6.2a", 0, 1, 0, 0, 2, 1);
        step(2, "T6.2b", 1, 1, 0, 0, 3, 1);
        step(2, "T6.2c", 1, 1, 0, 1, 1, 2);
        step(2, "T6.3a", 0, 1, 0, 0, 2, 2);
        step(2, "T6.3b", 1, 1, 0, 0, 3, 2);
        step(2, "T6.3c", 1, 1, 0, 1, 1, 3);
        step(2, "T6.4a", 0, 1, 0, 0, 2, 3);
        step(2, "T6.4b", 1, 1, 0, 0, 3, 3);
        step(2, "T6.4c", 1, 1, 0, 1, 1, 3);
        step(2, "T6.5a", 0, 1, 0, 0, 2, 3);
        step(2, "T6.5b", 1, 1, 0, 0, 3, 3);
        step(2, "T6.5c", 1, 1, 0, 1, 1, 3);
        step(2, "T6.clr_a", 0, 1, 0, 0, 2, 3);
        step(2, "T6.clr_b", 1, 1, 0, 0, 3, 3);
        step(2, "T6.clr_match", 1, 1, 1, 1, 1, 0);
        step(2, "T6.clr_only", 0, 1, 1, 0, 2, 0);
        step(2, "T6.after_a", 1, 1, 0, 0, 3, 0);
        step(2, "T6.after_b", 1, 1, 0, 1, 1, 1);

        // T1 async reset mid-stream at STATE=2, COUNT=5
        do_reset();
        step(0, "T1.1a", 1, 1, 0, 0, 1, 0);
        step(0, "T1.1b", 0, 1, 0, 0, 2, 0);
        step(0, "T1.1c", 1, 1, 0, 0, 3, 0);
        step(0, "T1.1d", 1, 1, 0, 1, 1, 1);
        for (int m = 2; m <= 5; m++) begin
            step(0, $sformatf("T1.%0da", m), 0, 1, 0, 0, 2, m - 1);
            step(0, $sformatf("T1.%0db", m), 1, 1, 0, 0, 3, m - 1);
            step(0, $sformatf("T1.%0dc", m), 1, 1, 0, 1, 1, m);
        end
        step(0, "T1.pre", 0, 1, 0, 0, 2, 5);
        #2;
        A   = 1'b1;
        B   = 1'b1;
        RST = 1'b0;
        #1;
        chk("T1.async Z", get_z(0), 0);
        chk("T1.async Y", get_y(0), 0);
        chk("T1.async X", get_x(0), 0);
        chk("T1.async STATE", get_st(0), 0);
        chk("T1.async COUNT", get_cnt(0), 0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        step(0, "T1.post1", 1, 1, 0, 0, 1, 0);
        step(0, "T1.post2", 0, 1, 0, 0, 2, 0);
        step(0, "T1.post3", 1, 1, 0, 0, 3, 0);
        step(0, "T1.post4", 1, 1, 0, 1, 1, 1);
        B = 1'b0;

        for (int w = 0; w < 20 && q.size() != 0; w++) begin
            @(posedge CLK);
        end
        repeat (2) @(posedge CLK);
        #3;
        chk("drain: queue entries left", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
